res_multiplier: RTL

//  Pipelined unsigned shift-add multiplier; the inverse datapath of the
//  non-restoring divider. Rebuilds a product from a 12-bit quotient and a
//  13-bit divisor, one partial product per stage, and accepts one operand

---
 rtl/res_multiplier.sv | 73 +++++++
 1 files changed

// File: rtl/res_multiplier.sv
// res_multiplier
//   Pipelined unsigned shift-add multiplier. It rebuilds quotient*divisor one
//   partial product per stage, LSB first. It accepts one operand pair per
//   clock and has no stall or backpressure. Latency from a sampled start to
//   done is QW+1 clock edges.
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active-high
//   start     operand-valid strobe; operands are sampled on the edge where start=1
//   quotient  [QW-1:0]    multiplier operand, unsigned
//   divisor   [DW-1:0]    multiplicand operand, unsigned
//   product   [QW+DW-1:0] registered quotient*divisor; holds its value between results
//   prod_hi   [DW-1:0]    upper DW bits of product (the result in dividend units)
//   done      pulses for one cycle per accepted start, in input order
module res_multiplier #(
    parameter int QW = 12,
    parameter int DW = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [QW-1:0]    quotient,
    input  logic [DW-1:0]    divisor,
    output logic [QW+DW-1:0] product,
    output logic [DW-1:0]    prod_hi,
    output logic             done
);

    localparam int PW = QW + DW;

    // Index k holds the operands entering stage k+1. The accumulator at index k
    // already includes the partial products of quotient bits 0..k-1.
    logic [QW-1:0] q_r   [0:QW-1];
    logic [DW-1:0] d_r   [0:QW-1];
    logic [PW-1:0] acc_r [0:QW];
    logic [QW:0]   v_r;
    logic [PW-1:0] pp    [1:QW];

    // Stage k adds divisor<<(k-1) when quotient bit k-1 is set. The bits are
    // consumed LSB first, so the running sum never exceeds PW bits.
    for (genvar k = 1; k <= QW; k++) begin : g_pp
        assign pp[k] = q_r[k-1][k-1] ? (PW'(d_r[k-1]) << (k-1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            v_r      <= {v_r[QW-1:0], start};
            q_r[0]   <= quotient;
            d_r[0]   <= divisor;
            acc_r[0] <= '0;
            for (int k = 1; k < QW; k++) begin
                q_r[k] <= q_r[k-1];
                d_r[k] <= d_r[k-1];
            end
            for (int k = 1; k <= QW; k++) begin
                acc_r[k] <= acc_r[k-1] + pp[k];
            end
            done <= v_r[QW];
            // A bubble leaves the last valid result on the output.
            if (v_r[QW]) begin
                product <= acc_r[QW];
            end
        end
    end

    assign prod_hi = product[PW-1:QW];

endmodule
